// File: rtl/ip4_rtl_spa_wb_pkg.sv
// Shared types and constants for the SPA write-back stage.
package ip4_rtl_pkg;

    localparam int unsigned NUM_FU      = 3;
    localparam int unsigned NUM_SP      = 8;
    localparam int unsigned WORD_BITS   = 32;
    localparam int unsigned NUM_BK      = 4;
    localparam int unsigned BK_W        = $clog2(NUM_BK);
    localparam int unsigned ADR_W       = 6;
    localparam int unsigned TID_W       = 3;
    localparam int unsigned SPAWB_DEPTH = 4;
    localparam int unsigned SPAWB_CNT_W = $clog2(SPAWB_DEPTH + 1);
    localparam int unsigned FU_W        = $clog2(NUM_FU);
    localparam int unsigned RES_W       = NUM_SP * WORD_BITS;

    typedef struct packed {
        logic              en;
        logic              wr;
        logic [BK_W-1:0]   bk;
        logic [ADR_W-1:0]  adr;
        logic [TID_W-1:0]  tid;
        logic [NUM_SP-1:0] emsk;
        logic [RES_W-1:0]  res;
        logic [NUM_SP-1:0] exp;
    } spa2wb_fu_s;

    typedef struct packed {
        logic [BK_W-1:0]   bk;
        logic [ADR_W-1:0]  adr;
        logic [TID_W-1:0]  tid;
        logic [NUM_SP-1:0] emsk;
        logic [RES_W-1:0]  res;
    } wb_entry_s;

    typedef struct packed {
        logic              en;
        logic [ADR_W-1:0]  adr;
        logic [NUM_SP-1:0] msk;
        logic [RES_W-1:0]  dat;
    } wb_port_s;

    // Round-robin pick starting at ptr; returns {found, index}.
    function automatic logic [FU_W:0] rr_pick(input logic [NUM_FU-1:0] req,
                                              input logic [FU_W-1:0]   ptr);
        logic            found;
        logic [FU_W-1:0] sel;
        int unsigned     idx;
        found = 1'b0;
        sel   = '0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NUM_FU) idx = idx - NUM_FU;
            if (!found && req[FU_W'(idx)]) begin
                found = 1'b1;
                sel   = FU_W'(idx);
            end
        end
        return {found, sel};
    endfunction

    function automatic logic [FU_W-1:0] rr_next(input logic [FU_W-1:0] sel);
        return (32'(sel) == NUM_FU - 1) ? '0 : FU_W'(sel + FU_W'(1));
    endfunction

    // Widens a lane mask to a full-vector data mask.
    function automatic logic [RES_W-1:0] msk_expand(input logic [NUM_SP-1:0] msk);
        logic [RES_W-1:0] m;
        for (int unsigned i = 0; i < NUM_SP; i++)
            m[i*WORD_BITS +: WORD_BITS] = {WORD_BITS{msk[i]}};
        return m;
    endfunction

endpackage

// File: rtl/ip4_rtl_spa_wb_if.sv
// SPA-side, register-file-side and exception-side signals of the write-back stage.
interface ip4_rtl_spa_wb_if;
    import ip4_rtl_pkg::*;

    logic [NUM_FU-1:0]               in_en;
    logic [NUM_FU-1:0]               in_wr;
    logic [NUM_FU*BK_W-1:0]          in_bk;
    logic [NUM_FU*ADR_W-1:0]         in_adr;
    logic [NUM_FU*TID_W-1:0]         in_tid;
    logic [NUM_FU*NUM_SP-1:0]        in_emsk;
    logic [NUM_FU*RES_W-1:0]         in_res;
    logic [NUM_FU*NUM_SP-1:0]        in_exp;
    logic                            stall;
    logic [NUM_BK-1:0]               wb_en;
    logic [NUM_BK*ADR_W-1:0]         wb_adr;
    logic [NUM_BK*NUM_SP-1:0]        wb_msk;
    logic [NUM_BK*RES_W-1:0]         wb_dat;
    logic                            exp_clr;
    logic                            exp;
    logic [TID_W-1:0]                exp_tid;
    logic [1:0]                      exp_fu;
    logic                            ovf;

    modport slave (
        input  in_en, in_wr, in_bk, in_adr, in_tid, in_emsk, in_res, in_exp, exp_clr,
        output stall, wb_en, wb_adr, wb_msk, wb_dat, exp, exp_tid, exp_fu, ovf
    );

    modport master (
        output in_en, in_wr, in_bk, in_adr, in_tid, in_emsk, in_res, in_exp, exp_clr,
        input  stall, wb_en, wb_adr, wb_msk, wb_dat, exp, exp_tid, exp_fu, ovf
    );

endinterface

// File: rtl/ip4_rtl_spa_wb_fifo.sv
// Per-FU write queue: synchronous FIFO of wb_entry_s; push into a full queue is accepted only with a pop.
module ip4_rtl_spa_wb_fifo
    import ip4_rtl_pkg::*;
#(
    parameter int unsigned DEPTH = SPAWB_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  wb_entry_s        din,
    output wb_entry_s        head_c,
    output logic [CNT_W-1:0] count,
    output logic             full_c,
    output logic             empty_c
);

    wb_entry_s        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full_c  = (count == CNT_W'(DEPTH));
    assign empty_c = (count == '0);
    assign pop_ok  = pop & ~empty_c;
    assign push_ok = push & (~full_c | pop_ok);
    assign head_c  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ip4_rtl_spa_wb.sv
// SPA write-back: per-FU queues, per-bank round-robin write arbitration, stall and sticky exception/overflow.
// Optional same-cycle bypass of empty queues under `IP4_SPAWB_BYPASS_EN.
module ip4_rtl_spa_wb
    import ip4_rtl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    ip4_rtl_spa_wb_if.slave  bus
);

    spa2wb_fu_s             fu      [NUM_FU];
    wb_entry_s              ent_in  [NUM_FU];
    wb_entry_s              head    [NUM_FU];
    logic [SPAWB_CNT_W-1:0] cnt     [NUM_FU];
    logic [NUM_FU-1:0]      push_req;
    logic [NUM_FU-1:0]      push;
    logic [NUM_FU-1:0]      pop;
    logic [NUM_FU-1:0]      full;
    logic [NUM_FU-1:0]      empty;
    logic [NUM_FU-1:0]      byp_cand;
    logic [NUM_FU-1:0]      byp_win;
    logic [NUM_FU-1:0]      hit;

    logic [FU_W-1:0]        rr_q    [NUM_BK];
    logic [FU_W-1:0]        rr_d    [NUM_BK];
    wb_port_s               port_q  [NUM_BK];
    wb_port_s               port_d  [NUM_BK];

    logic [NUM_FU-1:0]      head_req;
    logic [NUM_FU-1:0]      byp_req;
    logic [FU_W:0]          pick;
    wb_entry_s              ent;

    logic                   stall_c;
    logic                   exp_q;
    logic [TID_W-1:0]       exp_tid_q;
    logic [1:0]             exp_fu_q;
    logic                   ovf_q;
    logic                   hit_any;
    logic [TID_W-1:0]       hit_tid;
    logic [1:0]             hit_fu;

    // Unpack the flat SPA slots into per-FU records.
    always_comb begin
        for (int unsigned f = 0; f < NUM_FU; f++) begin
            fu[f].en   = bus.in_en[f];
            fu[f].wr   = bus.in_wr[f];
            fu[f].bk   = bus.in_bk[f*BK_W +: BK_W];
            fu[f].adr  = bus.in_adr[f*ADR_W +: ADR_W];
            fu[f].tid  = bus.in_tid[f*TID_W +: TID_W];
            fu[f].emsk = bus.in_emsk[f*NUM_SP +: NUM_SP];
            fu[f].res  = bus.in_res[f*RES_W +: RES_W];
            fu[f].exp  = bus.in_exp[f*NUM_SP +: NUM_SP];
            ent_in[f]  = '{bk: fu[f].bk, adr: fu[f].adr, tid: fu[f].tid,
                           emsk: fu[f].emsk, res: fu[f].res};
            push_req[f] = fu[f].en & fu[f].wr & (|fu[f].emsk);
            hit[f]      = fu[f].en & (|(fu[f].exp & fu[f].emsk));
        end
    end

`ifdef IP4_SPAWB_BYPASS_EN
    assign byp_cand = push_req & empty;
`else
    assign byp_cand = '0;
`endif

    assign push = push_req & ~byp_win;

    for (genvar f = 0; f < NUM_FU; f++) begin : g_q
        ip4_rtl_spa_wb_fifo #(.DEPTH(SPAWB_DEPTH)) u_q (
            .clk     (clk),
            .rst_n   (rst_n),
            .push    (push[f]),
            .pop     (pop[f]),
            .din     (ent_in[f]),
            .head_c  (head[f]),
            .count   (cnt[f]),
            .full_c  (full[f]),
            .empty_c (empty[f])
        );
    end

    // Per-bank arbitration: queue heads first, bypass candidates only when no head targets the bank.
    always_comb begin
        pop      = '0;
        byp_win  = '0;
        head_req = '0;
        byp_req  = '0;
        pick     = '0;
        ent      = '0;
        for (int unsigned b = 0; b < NUM_BK; b++) begin
            rr_d[b]   = rr_q[b];
            port_d[b] = '0;
            ent       = '0;
            for (int unsigned f = 0; f < NUM_FU; f++) begin
                head_req[f] = ~empty[f] & (head[f].bk == BK_W'(b));
                byp_req[f]  = byp_cand[f] & (fu[f].bk == BK_W'(b));
            end
            if (|head_req) begin
                pick           = rr_pick(head_req, rr_q[b]);
                pop[pick[FU_W-1:0]] = 1'b1;
                ent            = head[pick[FU_W-1:0]];
            end else if (|byp_req) begin
                pick           = rr_pick(byp_req, rr_q[b]);
                byp_win[pick[FU_W-1:0]] = 1'b1;
                ent            = ent_in[pick[FU_W-1:0]];
            end else begin
                pick           = '0;
            end
            if (pick[FU_W]) begin
                rr_d[b]       = rr_next(pick[FU_W-1:0]);
                port_d[b].en  = 1'b1;
                port_d[b].adr = ent.adr;
                port_d[b].msk = ent.emsk;
                port_d[b].dat = ent.res & msk_expand(ent.emsk);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned b = 0; b < NUM_BK; b++) begin
                rr_q[b]   <= '0;
                port_q[b] <= '0;
            end
        end else begin
            for (int unsigned b = 0; b < NUM_BK; b++) begin
                rr_q[b]   <= rr_d[b];
                port_q[b] <= port_d[b];
            end
        end
    end

    // Lowest-index hitting FU supplies the captured tid/fu.
    always_comb begin
        hit_any = 1'b0;
        hit_tid = '0;
        hit_fu  = '0;
        for (int unsigned f = 0; f < NUM_FU; f++) begin
            if (hit[f] && !hit_any) begin
                hit_any = 1'b1;
                hit_tid = fu[f].tid;
                hit_fu  = 2'(f);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q     <= 1'b0;
            exp_tid_q <= '0;
            exp_fu_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (hit_any && (!exp_q || bus.exp_clr)) begin
                exp_q     <= 1'b1;
                exp_tid_q <= hit_tid;
                exp_fu_q  <= hit_fu;
            end else if (bus.exp_clr) begin
                exp_q     <= 1'b0;
            end
            if (|(push & full & ~pop)) ovf_q <= 1'b1;
        end
    end

    always_comb begin
        stall_c = 1'b0;
        for (int unsigned f = 0; f < NUM_FU; f++)
            if (cnt[f] >= SPAWB_CNT_W'(SPAWB_DEPTH - 1)) stall_c = 1'b1;
    end

    always_comb begin
        for (int unsigned b = 0; b < NUM_BK; b++) begin
            bus.wb_en[b]                        = port_q[b].en;
            bus.wb_adr[b*ADR_W +: ADR_W]        = port_q[b].adr;
            bus.wb_msk[b*NUM_SP +: NUM_SP]      = port_q[b].msk;
            bus.wb_dat[b*RES_W +: RES_W]        = port_q[b].dat;
        end
    end

    assign bus.stall   = stall_c;
    assign bus.exp     = exp_q;
    assign bus.exp_tid = exp_tid_q;
    assign bus.exp_fu  = exp_fu_q;
    assign bus.ovf     = ovf_q;

endmodule

// File: doc/ip4_rtl_spa_wb.md
Name: ip4_rtl_spa_wb

Overview:
- Write-back stage directly downstream of the stream processor array (SPA).
- Each cycle it accepts up to NUM_FU per-FU vector results and queues them per FU.
- It arbitrates FU results onto NUM_BK single-write-port vector register file banks.
- It raises backpressure to issue and collects the sticky per-lane execution-exception summary for the exception unit.

Parameters:
- NUM_FU, 3, functional units per SPA issue slot.
- NUM_SP, 8, lanes (stream processors) per vector.
- WORD_BITS, 32, lane data width.
- NUM_BK, 4, register file banks; bank index width BK_W = $clog2(NUM_BK).
- ADR_W, 6, register address width within a bank.
- TID_W, 3, thread id width.
- DEPTH, 4, entries per per-FU write queue (power of 2, >= 2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_en  in  NUM_FU  FU slot valid from SPA.
- in_wr  in  NUM_FU  slot writes the register file.
- in_bk  in  NUM_FU*BK_W  destination bank.
- in_adr  in  NUM_FU*ADR_W  destination address.
- in_tid  in  NUM_FU*TID_W  thread id.
- in_emsk  in  NUM_FU*NUM_SP  lane enable mask.
- in_res  in  NUM_FU*NUM_SP*WORD_BITS  lane results (res0).
- in_exp  in  NUM_FU*NUM_SP  per-lane exception flags.
- stall  out  1  backpressure to issue/SPA.
- wb_en  out  NUM_BK  bank write strobe.
- wb_adr  out  NUM_BK*ADR_W  bank write address.
- wb_msk  out  NUM_BK*NUM_SP  bank lane write mask.
- wb_dat  out  NUM_BK*NUM_SP*WORD_BITS  bank write data.
- exp_clr  in  1  clear sticky exception.
- exp  out  1  sticky exception pending.
- exp_tid  out  TID_W  thread of the first exception.
- exp_fu  out  2  FU of the first exception.
- ovf  out  1  sticky queue overflow error.

Behaviour:
- Reset: all outputs 0; queues empty; round-robin pointers 0; exception and overflow state cleared.
- Enqueue:
  - Slot f is pushed when in_en[f] & in_wr[f] & |in_emsk[f].
  - Otherwise nothing is queued for that slot.
  - Entry contents: {bk, adr, tid, emsk, res}.
- Queue full:
  - A push into a full queue is dropped and sets ovf.
  - ovf stays set until reset.
- Stall:
  - stall is combinational from registered counts: 1 when any queue count >= DEPTH-1.
  - Upstream guarantees at most one further push per FU in the cycle after stall rises.
  - Therefore ovf never fires in legal operation.
- Arbitration (per bank b):
  - Candidates are queue heads with bk == b.
  - Round-robin over FU index starting at rr[b].
  - Winner f pops its head; rr[b] <= (f+1) mod NUM_FU.
  - rr[b] is unchanged when the bank has no grant.
  - Each bank grants at most one entry per cycle; each queue pops at most one entry per cycle.
- Write port timing:
  - wb_* are registered.
  - A granted head appears on wb_* of its bank in the cycle after the grant.
  - Minimum input-to-wb_en latency is 2 cycles: enqueue, then grant.
  - wb_dat lanes with wb_msk = 0 are don't-care but driven 0.
- Simultaneous push and pop on the same queue: count is unchanged; full-plus-pop accepts the push.
- Ordering: writes from one FU retire in issue order. Writes from different FUs to the same bank/address retire in arbitration order; issue logic guarantees no WAW hazard across FUs.
- Exceptions:
  - Hit condition: in_en[f] & |(in_exp[f] & in_emsk[f]), independent of in_wr.
  - On a hit while exp=0: set exp; capture exp_tid and exp_fu from the lowest-index hitting FU.
  - Further hits while exp=1 are ignored.
  - exp_clr clears exp. If exp_clr and a hit occur in the same cycle, the hit wins: exp stays 1 and new tid/fu are captured.
- Reset mid-operation discards all queued writes; no partial bank write is emitted.

Optional Feature:
- Macro: IP4_SPAWB_BYPASS_EN.
- When defined, a pushing slot whose queue is empty competes in the same-cycle arbitration alongside the heads.
  - If it wins, it is not enqueued and reaches wb_* in the next cycle (1-cycle latency).
  - Existing heads keep priority over bypass candidates of the same bank.
- When undefined, all writes pass through the queues (minimum 2-cycle latency).

Decomposition:
- ip4_rtl_pkg carries:
  - spa2wb_fu_s (en, wr, bk, adr, tid, emsk, res, exp).
  - wb_entry_s.
  - wb_port_s.
  - Constants NUM_BK and SPAWB_DEPTH.
- Sub-module ip4_rtl_spa_wb_fifo:
  - Parametrised sync FIFO of wb_entry_s with push, pop, head, count, full.
  - Instantiated NUM_FU times.

Test Plan:
- FU0 write, bk=2, adr=5, emsk=8'hFF, data lane i = i -> wb_en=4'b0100 exactly 2 cycles later, wb_adr[2]=5, wb_dat lanes 0..7; no other bank strobes.
- FU0/1/2 all bk=1 in one cycle, rr[1]=0 -> bank 1 writes FU0, FU1, FU2 on consecutive cycles. A repeat conflict after rr[1]=0 again yields the same order; with rr[1]=2 the order is FU2, FU0, FU1.
- FU0 and FU1 stream bk=0 every cycle, honouring stall with 1-cycle reaction -> stall toggles, bank 0 retires one write per cycle, ovf stays 0, no write lost (count check).
- FU1 tid=5, in_exp=8'h08, emsk=8'h08 -> exp=1, exp_tid=5, exp_fu=1. Same with emsk=8'h00 -> exp stays 0. exp_clr coincident with a new hit on tid=2 -> exp=1, exp_tid=2.
- Queue 3 entries, assert rst_n=0 for one cycle -> no wb_en after release, stall=0, counts 0.
- IP4_SPAWB_BYPASS_EN on, idle queues, FU2 bk=3 -> wb_en[3] in the next cycle; with FU0 head pending on bk=3, the head writes first and FU2 writes the following cycle.
